// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR ADC controller.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } sar_state_e;

    // Cycle counter must hold the longest per-phase count.
    function automatic int unsigned cnt_width(input int unsigned sample_cycles,
                                              input int unsigned settle_cycles);
        int unsigned longest;
        longest = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
        return $clog2(longest + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, cleared by reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives the resistor DAC, reads the
// comparator through a synchronizer and binary-searches a WIDTH-bit result.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int unsigned CNT_W = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int unsigned IDX_W = idx_width(WIDTH);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 12) begin : g_bad_width
        $error("sar_adc_ctrl: WIDTH must be in 2..12");
    end
    if (SAMPLE_CYCLES < 1) begin : g_bad_sample
        $error("sar_adc_ctrl: SAMPLE_CYCLES must be >= 1");
    end
    // The decision reads cmp_in two edges late, so one settle cycle would see the old DAC code.
    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("sar_adc_ctrl: SETTLE_CYCLES must be >= 2");
    end

    logic cmp_s;

    sync_2ff u_cmp_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cmp_in),
        .q     (cmp_s)
    );

    sar_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             sample_en_q, sample_en_d;
    logic [WIDTH-1:0] dac_code_q, dac_code_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                    idx_d   = IDX_MSB;
                    acc_d   = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = DECIDE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DECIDE: begin
                acc_d[idx_q] = cmp_s;
                if (idx_q == '0) begin
                    state_d        = DONE;
                    result_d       = acc_d;
                    result_valid_d = 1'b1;
                end else begin
                    state_d = SETTLE;
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered pins track the state register.
        sample_en_d = (state_d == SAMPLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        case (state_d)
            SETTLE, DECIDE: dac_code_d = acc_d | (WIDTH'(1) << idx_d);
            DONE:           dac_code_d = result_d;
            default:        dac_code_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            sample_en_q    <= 1'b0;
            dac_code_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            sample_en_q    <= sample_en_d;
            dac_code_q     <= dac_code_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign sample_en    = sample_en_q;
    assign dac_code     = dac_code_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed self-checking bench for sar_adc_ctrl with a behavioural comparator per instance.
module tb_sar_adc_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       start_m, cmp_m, samp_m, busy_m, done_m, rv_m;
    logic [7:0] dac_m, res_m, vin_m;
    assign cmp_m = (vin_m >= dac_m);

    sar_adc_ctrl u_main (
        .clk(clk), .reset(reset), .start(start_m), .cmp_in(cmp_m),
        .sample_en(samp_m), .dac_code(dac_m), .busy(busy_m), .done(done_m),
        .result(res_m), .result_valid(rv_m)
    );

    // Minimum-settle instance with comparator glitch injection
    logic       start_s, cmp_s, glitch_s, samp_s, busy_s, done_s, rv_s;
    logic [7:0] dac_s, res_s, vin_s;
    assign cmp_s = (vin_s >= dac_s) ^ glitch_s;

    sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(2)) u_settle2 (
        .clk(clk), .reset(reset), .start(start_s), .cmp_in(cmp_s),
        .sample_en(samp_s), .dac_code(dac_s), .busy(busy_s), .done(done_s),
        .result(res_s), .result_valid(rv_s)
    );

    // Narrow instance
    logic       start_w, cmp_w, samp_w, busy_w, done_w, rv_w;
    logic [3:0] dac_w, res_w, vin_w;
    assign cmp_w = (vin_w >= dac_w);

    sar_adc_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(2)) u_w4 (
        .clk(clk), .reset(reset), .start(start_w), .cmp_in(cmp_w),
        .sample_en(samp_w), .dac_code(dac_w), .busy(busy_w), .done(done_w),
        .result(res_w), .result_valid(rv_w)
    );

    int n_chk;
    int n_pass;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start_m = 1'b0; start_s = 1'b0; start_w = 1'b0;
        vin_m = '0; vin_s = '0; vin_w = '0; glitch_s = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        n_chk++; if (busy_m !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy_m); else n_pass++;
        n_chk++; if (done_m !== 1'b0) $display("FAIL reset_done: got %b exp 0", done_m); else n_pass++;
        n_chk++; if (samp_m !== 1'b0) $display("FAIL reset_sample_en: got %b exp 0", samp_m); else n_pass++;
        n_chk++; if (dac_m !== 8'h00) $display("FAIL reset_dac: got %h exp 00", dac_m); else n_pass++;
        n_chk++; if (res_m !== 8'h00) $display("FAIL reset_result: got %h exp 00", res_m); else n_pass++;
        n_chk++; if (rv_m !== 1'b0) $display("FAIL reset_valid: got %b exp 0", rv_m); else n_pass++;
        tick;
        n_chk++; if (busy_m !== 1'b0) $display("FAIL idle_busy: got %b exp 0", busy_m); else n_pass++;
    endtask

    // VIN=0xA5: full trial sequence, sample window and done timing.
    task automatic test_single;
        logic [7:0] tr [8];
        logic [7:0] exp_dac;
        logic       exp_samp, exp_done, exp_busy;
        tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vin_m = 8'hA5;
        start_m = 1'b1;
        tick;
        start_m = 1'b0;
        n_chk++; if (samp_m !== 1'b1) $display("FAIL t1_sample_e0: got %b exp 1", samp_m); else n_pass++;
        n_chk++; if (busy_m !== 1'b1) $display("FAIL t1_busy_e0: got %b exp 1", busy_m); else n_pass++;
        for (int e = 1; e <= 43; e++) begin
            tick;
            exp_samp = (e == 1);
            exp_done = (e == 42);
            exp_busy = (e <= 42);
            if (e >= 2 && e <= 41) exp_dac = tr[(e - 2) / 5];
            else if (e == 42)      exp_dac = 8'hA5;
            else                   exp_dac = 8'h00;
            n_chk++; if (samp_m !== exp_samp) $display("FAIL t1_sample e=%0d: got %b exp %b", e, samp_m, exp_samp); else n_pass++;
            n_chk++; if (dac_m !== exp_dac) $display("FAIL t1_dac e=%0d: got %h exp %h", e, dac_m, exp_dac); else n_pass++;
            n_chk++; if (done_m !== exp_done) $display("FAIL t1_done e=%0d: got %b exp %b", e, done_m, exp_done); else n_pass++;
            n_chk++; if (busy_m !== exp_busy) $display("FAIL t1_busy e=%0d: got %b exp %b", e, busy_m, exp_busy); else n_pass++;
            if (e == 41) begin
                n_chk++; if (res_m !== 8'h00) $display("FAIL t1_result_hold: got %h exp 00", res_m); else n_pass++;
                n_chk++; if (rv_m !== 1'b0) $display("FAIL t1_valid_early: got %b exp 0", rv_m); else n_pass++;
            end
            if (e == 42) begin
                n_chk++; if (res_m !== 8'hA5) $display("FAIL t1_result: got %h exp a5", res_m); else n_pass++;
                n_chk++; if (rv_m !== 1'b1) $display("FAIL t1_valid: got %b exp 1", rv_m); else n_pass++;
            end
        end
    endtask

    // VIN=0x00 then 0xFF with start held high: done spacing and single idle gap.
    task automatic test_back_to_back;
        int t1, t2, idle_cnt;
        t1 = -1; t2 = -1; idle_cnt = 0;
        vin_m = 8'h00;
        start_m = 1'b1;
        tick;
        for (int e = 1; e <= 120 && t2 < 0; e++) begin
            tick;
            if (done_m === 1'b1) begin
                if (t1 < 0) begin
                    t1 = e;
                    n_chk++; if (res_m !== 8'h00) $display("FAIL b2b_result0: got %h exp 00", res_m); else n_pass++;
                    vin_m = 8'hFF;
                end else begin
                    t2 = e;
                    n_chk++; if (res_m !== 8'hFF) $display("FAIL b2b_result1: got %h exp ff", res_m); else n_pass++;
                end
            end else if (t1 >= 0 && busy_m !== 1'b1) begin
                idle_cnt++;
            end
        end
        start_m = 1'b0;
        n_chk++; if (t1 != 42) $display("FAIL b2b_first_done: got edge %0d exp 42", t1); else n_pass++;
        n_chk++; if (t2 - t1 != 44) $display("FAIL b2b_spacing: got %0d (t2=%0d) exp 44", t2 - t1, t2); else n_pass++;
        n_chk++; if (idle_cnt != 1) $display("FAIL b2b_idle_gap: got %0d exp 1", idle_cnt); else n_pass++;
        tick;
        n_chk++; if (busy_m !== 1'b0) $display("FAIL b2b_stop: got %b exp 0", busy_m); else n_pass++;
    endtask

    // start pulses while busy (including the DONE cycle) must not retrigger.
    task automatic test_ignore_start;
        int n_done, t_done;
        logic [7:0] r;
        n_done = 0; t_done = -1; r = '0;
        vin_m = 8'h3C;
        start_m = 1'b1;
        tick;
        for (int e = 1; e <= 60; e++) begin
            start_m = (e == 5 || e == 20 || e == 42 || e == 43);
            tick;
            if (done_m === 1'b1) begin
                n_done++;
                if (t_done < 0) begin t_done = e; r = res_m; end
            end
        end
        start_m = 1'b0;
        n_chk++; if (n_done != 1) $display("FAIL ign_done_count: got %0d exp 1", n_done); else n_pass++;
        n_chk++; if (t_done != 42) $display("FAIL ign_done_edge: got %0d exp 42", t_done); else n_pass++;
        n_chk++; if (r !== 8'h3C) $display("FAIL ign_result: got %h exp 3c", r); else n_pass++;
        n_chk++; if (busy_m !== 1'b0) $display("FAIL ign_busy_after: got %b exp 0", busy_m); else n_pass++;
    endtask

    // Reset mid-conversion aborts silently; a fresh start then converts normally.
    task automatic test_reset_abort;
        int n_done, t_done;
        n_done = 0; t_done = -1;
        vin_m = 8'h77;
        start_m = 1'b1;
        tick;
        start_m = 1'b0;
        for (int e = 1; e <= 19; e++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_chk++; if (busy_m !== 1'b0) $display("FAIL abort_busy: got %b exp 0", busy_m); else n_pass++;
        n_chk++; if (dac_m !== 8'h00) $display("FAIL abort_dac: got %h exp 00", dac_m); else n_pass++;
        n_chk++; if (samp_m !== 1'b0) $display("FAIL abort_sample_en: got %b exp 0", samp_m); else n_pass++;
        n_chk++; if (res_m !== 8'h00) $display("FAIL abort_result: got %h exp 00", res_m); else n_pass++;
        n_chk++; if (rv_m !== 1'b0) $display("FAIL abort_valid: got %b exp 0", rv_m); else n_pass++;
        n_chk++; if (done_m !== 1'b0) $display("FAIL abort_done: got %b exp 0", done_m); else n_pass++;
        for (int e = 0; e < 30; e++) begin
            tick;
            if (done_m === 1'b1 || busy_m === 1'b1) n_done++;
        end
        n_chk++; if (n_done != 0) $display("FAIL abort_quiet: got %0d active cycles exp 0", n_done); else n_pass++;
        start_m = 1'b1;
        tick;
        start_m = 1'b0;
        for (int e = 1; e <= 80 && t_done < 0; e++) begin
            tick;
            if (done_m === 1'b1) t_done = e;
        end
        n_chk++; if (t_done != 42) $display("FAIL abort_redo_edge: got %0d exp 42", t_done); else n_pass++;
        n_chk++; if (res_m !== 8'h77) $display("FAIL abort_redo_result: got %h exp 77", res_m); else n_pass++;
        n_chk++; if (rv_m !== 1'b1) $display("FAIL abort_redo_valid: got %b exp 1", rv_m); else n_pass++;
    endtask

    // One-cycle inverted comparator in the cycle that ends at each SETTLE entry edge.
    task automatic test_glitch;
        int t_done;
        t_done = -1;
        vin_s = 8'h55;
        start_s = 1'b1;
        tick;
        start_s = 1'b0;
        for (int e = 1; e <= 60 && t_done < 0; e++) begin
            tick;
            if (done_s === 1'b1) t_done = e;
            glitch_s = (e <= 22 && ((e - 1) % 3) == 0);
        end
        glitch_s = 1'b0;
        n_chk++; if (t_done != 26) $display("FAIL glitch_done_edge: got %0d exp 26", t_done); else n_pass++;
        n_chk++; if (res_s !== 8'h55) $display("FAIL glitch_result: got %h exp 55", res_s); else n_pass++;
        n_chk++; if (rv_s !== 1'b1) $display("FAIL glitch_valid: got %b exp 1", rv_s); else n_pass++;
    endtask

    // WIDTH=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=2 with VIN=9.
    task automatic test_width4;
        logic [3:0] tr [4];
        logic [3:0] exp_dac;
        logic       exp_done;
        tr = '{4'h8, 4'hC, 4'hA, 4'h9};
        vin_w = 4'h9;
        start_w = 1'b1;
        tick;
        start_w = 1'b0;
        n_chk++; if (samp_w !== 1'b1) $display("FAIL w4_sample_e0: got %b exp 1", samp_w); else n_pass++;
        for (int e = 1; e <= 14; e++) begin
            tick;
            exp_done = (e == 13);
            if (e <= 12)      exp_dac = tr[(e - 1) / 3];
            else if (e == 13) exp_dac = 4'h9;
            else              exp_dac = 4'h0;
            n_chk++; if (dac_w !== exp_dac) $display("FAIL w4_dac e=%0d: got %h exp %h", e, dac_w, exp_dac); else n_pass++;
            n_chk++; if (done_w !== exp_done) $display("FAIL w4_done e=%0d: got %b exp %b", e, done_w, exp_done); else n_pass++;
            if (e == 13) begin
                n_chk++; if (res_w !== 4'h9) $display("FAIL w4_result: got %h exp 9", res_w); else n_pass++;
                n_chk++; if (rv_w !== 1'b1) $display("FAIL w4_valid: got %b exp 1", rv_w); else n_pass++;
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset;
        test_single;
        test_back_to_back;
        test_ignore_start;
        test_reset_abort;
        test_glitch;
        test_width4;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
